// File: rtl/chunked_adder_pkg.sv
// Shared types and defaults for the chunked (multi-cycle ripple) adder.
package chunked_adder_pkg;

  // Default operand width and bits added per cycle.
  localparam int DEF_WIDTH = 16;
  localparam int DEF_CHUNK = 4;

  // Operation sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/chunked_adder_chunk_add.sv
// Combinational W-bit adder slice with carry in and carry out.
module chunk_add #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic         cout,
  output logic [W-1:0] sum
);

  // One extra bit keeps the slice carry-out; nothing is truncated.
  logic [W:0] full;

  // Widen every operand to W+1 bits before adding.
  always_comb begin
    full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
  end

  assign sum  = full[W-1:0];
  assign cout = full[W];

endmodule

// File: rtl/chunked_adder.sv
// Multi-cycle adder: adds CHUNK bits per cycle, LSB slice first, rippling
// the carry through a register. Results are valid when done pulses and hold
// until the next accepted start.
//
// Handshake: start is a request sampled only while idle (busy=0); the edge
// that sees start=1 in IDLE captures a, b and cin. busy stays high from the
// cycle after that edge through the done cycle. done is a one-cycle pulse;
// sum/cout/ovf are valid on it and stay stable until the next accepting edge.
module chunked_adder
  import chunked_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output state_t           state_dbg
);

  // WIDTH must be a multiple of CHUNK, CHUNK >= 1.
  localparam int NSLICE = WIDTH / CHUNK;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  a_q, b_q, sum_q;
  logic              carry_q, cout_q, ovf_q;
  logic [IDXW-1:0]   idx_q;

  logic [CHUNK-1:0]  slice_a, slice_b, slice_sum;
  logic              slice_cout;
  logic              last;

  assign last = (idx_q == IDXW'(NSLICE - 1));

  // Select the current slice of the latched operands.
  always_comb begin
    slice_a = '0;
    slice_b = '0;
    for (int i = 0; i < NSLICE; i++) begin
      if (idx_q == IDXW'(i)) begin
        slice_a = a_q[i*CHUNK +: CHUNK];
        slice_b = b_q[i*CHUNK +: CHUNK];
      end
    end
  end

  chunk_add #(
    .W(CHUNK)
  ) u_chunk_add (
    .a   (slice_a),
    .b   (slice_b),
    .cin (carry_q),
    .cout(slice_cout),
    .sum (slice_sum)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: DONE always lasts one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ADD;
      ADD:     if (last)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Status outputs decoded from state.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      ADD:     busy = 1'b1;
      DONE:    begin busy = 1'b1; done = 1'b1; end
      default: ;
    endcase
  end

  // Datapath: capture operands on accept, then one slice per ADD cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            carry_q <= cin;
            idx_q   <= '0;
          end
        end
        ADD: begin
          for (int i = 0; i < NSLICE; i++) begin
            if (idx_q == IDXW'(i)) sum_q[i*CHUNK +: CHUNK] <= slice_sum;
          end
          carry_q <= slice_cout;
          idx_q   <= idx_q + IDXW'(1);
          if (last) begin
            cout_q <= slice_cout;
            // The MSB of the sum is produced by this final slice.
            ovf_q  <= (a_q[WIDTH-1] == b_q[WIDTH-1]) &&
                      (slice_sum[CHUNK-1] != a_q[WIDTH-1]);
          end
        end
        default: ;
      endcase
    end
  end

  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_chunked_adder.sv
// Directed bench for chunked_adder: a vector table for the main function
// plus hand-written sequences for the multi-cycle corner cases.
module tb_chunked_adder;
  import chunked_adder_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Default instance (16/4).
  logic        start = 1'b0;
  logic [15:0] a = '0, b = '0;
  logic        cin = 1'b0;
  logic        busy, done, cout, ovf;
  logic [15:0] sum;
  state_t      st;

  chunked_adder u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf),
    .state_dbg(st)
  );

  // Single-slice instance (8/8).
  logic       start8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8, ovf8;
  logic [7:0] sum8;
  state_t     st8;

  chunked_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8), .ovf(ovf8),
    .state_dbg(st8)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  // ---------------- drivers ----------------
  // Called #1 after an edge. Operands are scrambled after the accepting edge
  // so a result that depends on live inputs is caught.
  task automatic run_op(input string name, input vec_t v);
    int cyc;
    bit seen;
    a = v.a; b = v.b; cin = v.cin; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; a = ~v.a; b = ~v.b; cin = ~v.cin;
    cyc = 1; seen = 1'b0;
    while (!seen && cyc <= 20) begin
      if (done === 1'b1) seen = 1'b1;
      else begin @(posedge clk); #1; cyc++; end
    end
    chk({name, "_latency"}, cyc, 5);
    chk({name, "_sum"}, sum, v.sum);
    chk({name, "_cout"}, cout, v.cout);
    chk({name, "_ovf"}, ovf, v.ovf);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, done, 1'b0);
    chk({name, "_idle"}, busy, 1'b0);
    chk({name, "_sum_hold"}, sum, v.sum);
  endtask

  task automatic run_op8(input string name, input logic [7:0] ta, input logic [7:0] tb_,
                         input logic [7:0] es, input logic ec, input logic eo);
    int cyc;
    bit seen;
    a8 = ta; b8 = tb_; cin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = ~ta; b8 = ~tb_;
    chk({name, "_add_busy"}, busy8, 1'b1);
    cyc = 1; seen = 1'b0;
    while (!seen && cyc <= 20) begin
      if (done8 === 1'b1) seen = 1'b1;
      else begin @(posedge clk); #1; cyc++; end
    end
    chk({name, "_latency"}, cyc, 2);
    chk({name, "_sum"}, sum8, es);
    chk({name, "_cout"}, cout8, ec);
    chk({name, "_ovf"}, ovf8, eo);
    @(posedge clk); #1;
    chk({name, "_done_pulse"}, done8, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int d1, d2;
    vecs[0] = '{16'h7EED, 16'h3333, 1'b0, 16'hB220, 1'b0, 1'b1};
    vecs[1] = '{16'h8888, 16'h8ABC, 1'b0, 16'h1344, 1'b1, 1'b1};
    vecs[2] = '{16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0};
    vecs[4] = '{16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};
    vecs[6] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[8] = '{16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0};
    vecs[9] = '{16'h8888, 16'h8ABC, 1'b1, 16'h1345, 1'b1, 1'b1};

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", st, IDLE);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sum", sum, 16'h0000);
    chk("rst_cout", cout, 1'b0);
    chk("rst_ovf", ovf, 1'b0);
    chk("rst_sum8", sum8, 8'h00);
    rst = 1'b0;

    // Main function table.
    for (int i = 0; i < 10; i++) run_op($sformatf("vec%0d", i), vecs[i]);

    // Reset during the second ADD cycle (previous cout/ovf are 1).
    a = 16'h7EED; b = 16'h3333; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); #1;
    chk("midrst_pre_busy", busy, 1'b1);
    rst = 1'b1;
    #1;
    chk("midrst_state", st, IDLE);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_done", done, 1'b0);
    chk("midrst_sum", sum, 16'h0000);
    chk("midrst_cout", cout, 1'b0);
    chk("midrst_ovf", ovf, 1'b0);
    @(posedge clk); #1;
    chk("midrst_hold_done", done, 1'b0);
    rst = 1'b0;
    run_op("after_rst", '{16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0});

    // start re-pulsed and a changed during ADD: ignored.
    a = 16'h1234; b = 16'h4321; cin = 1'b0; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    for (int cyc = 1; cyc <= 6; cyc++) begin
      if (cyc == 2) begin start = 1'b1; a = 16'hFFFF; end
      if (cyc == 3) start = 1'b0;
      if (cyc <= 5) begin
        chk($sformatf("ignore_busy_c%0d", cyc), busy, 1'b1);
        chk($sformatf("ignore_done_c%0d", cyc), done, (cyc == 5) ? 1'b1 : 1'b0);
      end else begin
        chk("ignore_busy_after", busy, 1'b0);
        chk("ignore_done_after", done, 1'b0);
      end
      if (cyc == 5) chk("ignore_sum", sum, 16'h5555);
      @(posedge clk); #1;
    end

    // Back-to-back with start held high: one result every 6 cycles.
    a = 16'h0001; b = 16'h0002; cin = 1'b0; start = 1'b1;
    d1 = 0; d2 = 0;
    for (int cyc = 1; cyc <= 30 && d2 == 0; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 1) begin a = 16'h0003; b = 16'h0004; end
      if (done === 1'b1) begin
        if (d1 == 0) begin
          d1 = cyc;
          chk("b2b_sum1", sum, 16'h0003);
        end else begin
          d2 = cyc;
          chk("b2b_sum2", sum, 16'h0007);
          start = 1'b0;
        end
      end
    end
    start = 1'b0;
    chk("b2b_first_done", d1, 5);
    chk("b2b_second_done", d2, 11);
    @(posedge clk); #1;

    // Single-slice configuration.
    run_op8("w8_7f01", 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1);
    run_op8("w8_ff01", 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0);
    run_op8("w8_8080", 8'h80, 8'h80, 8'h00, 1'b1, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Hard stop if the sequence ever wedges.
  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
